instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//   Sequences the 256x16 program ROM. Owns the PC and drives the ROM address.
//   Buffers fetched words in a small prefetch queue and hands {pc, instruction} to decode over a valid/ready handshake.
//   Accepts jump/branch redirects from execute, which flush the queue.
//   Sits between the program ROM and the decode/control unit.
// PARAMETERS
//   ADDR_W      8      ROM address / PC width
//   INSTR_W     16     instruction width; opcode = [INSTR_W-1 -: 4]
//   QDEPTH      2      prefetch queue entries; power of 2, >= 2
//   RESET_PC    0      PC value after reset
//   HALT_OPCODE 4'hF   opcode treated as HALT (only with IFETCH_HALT_DETECT_EN)
// PORTS
//   clk            in   1                    rising-edge clock
//   rst_n          in   1                    async active-low reset
//   enable         in   1                    1 = fetch allowed
//   imem_addr      out  ADDR_W               ROM address (= pc, combinational)
//   imem_instr     in   INSTR_W              ROM data; combinational read of imem_addr
//   redirect_valid in   1                    jump/branch taken this cycle
//   redirect_pc    in   ADDR_W               jump target
//   instr_valid    out  1                    queue head valid
//   instr_data     out  INSTR_W              queue head instruction
//   instr_pc       out  ADDR_W               address of the queue head instruction
//   instr_ready    in   1                    decode accepts head
//   q_count        out  $clog2(QDEPTH)+1     queue occupancy
//   halted         out  1                    HALT fetched; fetch stopped
// BEHAVIOUR
//   Clock and reset
//   - Single clock domain: clk.
//   - rst_n is asynchronous, active-low. On assertion:
//     - pc = RESET_PC
//     - state = IDLE
//     - queue emptied; q_count = 0
//     - instr_valid = 0; halted = 0
//     - instr_data and instr_pc = 0
//   - Reset mid-operation discards all queued entries.
//   State machine
//   - States: IDLE, FETCH, HALTED.
//   - IDLE -> FETCH when enable = 1.
//   - FETCH -> IDLE when enable = 0. Queue is retained and keeps draining.
//   - FETCH -> HALTED on HALT enqueue (macro only).
//   - HALTED -> FETCH only on redirect_valid; halted is cleared.
//   - Neither enable nor its removal exits HALTED.
//   Datapath
//   - imem_addr = pc at all times.
//   - pop = instr_valid & instr_ready.
//   - Enqueue happens in FETCH when redirect_valid = 0 and (q_count < QDEPTH or pop).
//     - Writes {pc, imem_instr} to the tail.
//     - pc <= pc + 1, modulo 2^ADDR_W: 8'hFF wraps to 8'h00.
//   - Queue full with no pop: no enqueue; pc holds.
//   - Simultaneous pop and enqueue: q_count unchanged.
//   - Fetch-to-decode latency: 1 cycle. A word enqueued at edge N is visible on instr_* after edge N.
//   - instr_valid = (q_count != 0). instr_data/instr_pc hold the head; they are stable while valid & !ready.
//   Redirect
//   - Highest priority, honoured in every state.
//   - Same edge: queue flushed (q_count <= 0); pc <= redirect_pc; no enqueue.
//   - A pop in the same cycle is absorbed by the flush (decode has consumed it).
//   - Redirect in IDLE loads pc and stays IDLE.
//   - First post-redirect word is valid 1 cycle later if in FETCH.
//   Queue pointers
//   - Read and write pointers wrap modulo QDEPTH.
//   - Full and empty are distinguished by q_count.
// CONFIGURATION
//   IFETCH_HALT_DETECT_EN defined:
//   - An enqueued word whose opcode == HALT_OPCODE moves the FSM to HALTED on that edge.
//   - pc stays at the HALT address (no increment); halted = 1 from the next cycle.
//   - The HALT word itself is enqueued and drains normally.
//   IFETCH_HALT_DETECT_EN undefined:
//   - HALT words are fetched like any other word; fetch continues until enable = 0.
//   - halted is tied to 0; HALTED is unreachable.
// TESTING
//   1. Reset, enable = 1, instr_ready = 1, ROM[0..3] distinct:
//      -> instr_pc 0,1,2,3 on consecutive cycles; first valid 1 cycle after enable.
//   2. instr_ready = 0 for 5 cycles:
//      -> q_count saturates at 2; pc stops at 2; head stays pc 0.
//      Release ready -> pcs 0,1,2 delivered in order with no loss.
//   3. At pc = 5, pulse redirect_valid with redirect_pc = 13 while queue is full:
//      -> q_count = 0 next cycle; next delivered instr_pc = 13.
//   4. redirect_pc = 8'hFE, ready = 1:
//      -> delivered pcs FE, FF, 00, 01 (wrap).
//   5. HALT at ROM[14] with macro defined:
//      -> halted = 1; pc holds 14; queue drains to the HALT word.
//      redirect_pc = 0 -> halted = 0; fetch resumes at 0.
//      Without the macro: pc continues to 15; halted stays 0.
//   6. Assert rst_n low mid-fetch with q_count = 2:
//      -> instr_valid = 0 and pc = 0 immediately (asynchronous); after release, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads the program ROM and buffers fetched words
// in a small prefetch queue for decode. HALT detection is compiled in with IFETCH_HALT_DETECT_EN.
module instr_fetch_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter int          INSTR_W     = 16,
    parameter int          QDEPTH      = 2,
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]           imem_instr,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         instr_valid,
    output logic [INSTR_W-1:0]           instr_data,
    output logic [ADDR_W-1:0]            instr_pc,
    input  logic                         instr_ready,
    output logic [$clog2(QDEPTH):0]      q_count,
    output logic                         halted,
    output logic [1:0]                   dbg_state
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Handshake: a word moves to decode on any rising edge where instr_valid and
    // instr_ready are both high; instr_data/instr_pc are held stable until then.

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   pc;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   q_pc    [QDEPTH];
    logic [INSTR_W-1:0]  q_instr [QDEPTH];

    logic pop;
    logic enq;
    logic halt_hit;

    assign imem_addr   = pc;
    assign instr_valid = (count != '0);
    assign instr_data  = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign q_count     = count;
    assign dbg_state   = state;

    assign pop = instr_valid & instr_ready;
    // A pop frees the slot being written this edge, so a full queue can still accept.
    assign enq = (state == FETCH) && !redirect_valid && ((count < CNT_W'(QDEPTH)) || pop);

`ifdef IFETCH_HALT_DETECT_EN
    assign halt_hit = enq && (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
    assign halted   = (state == HALTED);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && enable) state_n = FETCH;
            end
            FETCH: begin
                if (!enable)       state_n = IDLE;
                else if (halt_hit) state_n = HALTED;
            end
            HALTED: begin
                if (redirect_valid) state_n = FETCH;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (enq && !halt_hit) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Redirect flushes everything, including a head popped on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (enq && !pop)      count <= count + CNT_W'(1);
            else if (pop && !enq) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (enq) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: behavioural ROM, linear stimulus, immediate-assertion checks.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;
    logic        instr_ready;
    logic [1:0]  q_count;
    logic        halted;
    logic [1:0]  dbg_state;

    logic [15:0] rom [256];
    int checks   = 0;
    int failures = 0;

    instr_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .q_count        (q_count),
        .halted         (halted),
        .dbg_state      (dbg_state)
    );

    assign imem_instr = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'h10, 8'(i)};
        rom[14] = 16'hF00E;

        // Reset
        rst_n = 1'b0; enable = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        tick(); tick();
        check("rst_q_count", 32'(q_count), 0);
        check("rst_valid",   32'(instr_valid), 0);
        check("rst_addr",    32'(imem_addr), 0);
        check("rst_halted",  32'(halted), 0);
        check("rst_ipc",     32'(instr_pc), 0);
        check("rst_idata",   32'(instr_data), 0);
        check("rst_state",   32'(dbg_state), 0);
        rst_n = 1'b1;
        tick();

        // Sequential fetch 0..3
        enable = 1'b1; instr_ready = 1'b1;
        tick();
        check("t1_state_fetch", 32'(dbg_state), 1);
        check("t1_not_valid",   32'(instr_valid), 0);
        tick();
        check("t1_valid",  32'(instr_valid), 1);
        check("t1_data0",  32'(instr_data), 32'h1000);
        check("t1_count",  32'(q_count), 1);
        check("t1_pc0",    32'(instr_pc), 0);
        tick(); check("t1_pc1", 32'(instr_pc), 1);
        tick(); check("t1_pc2", 32'(instr_pc), 2);
        tick(); check("t1_pc3", 32'(instr_pc), 3);
        check("t1_addr4", 32'(imem_addr), 4);

        // Backpressure saturates queue at 2
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("bp_count", 32'(q_count), 2);
        check("bp_addr",  32'(imem_addr), 5);
        check("bp_head",  32'(instr_pc), 3);

        // Redirect to 13 while full at pc 5
        redirect_valid = 1'b1; redirect_pc = 8'd13;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        check("rd_count", 32'(q_count), 0);
        check("rd_valid", 32'(instr_valid), 0);
        check("rd_addr",  32'(imem_addr), 13);
        tick();
        check("rd_pc13",   32'(instr_pc), 13);
        check("rd_data13", 32'(instr_data), 32'h100D);

        // HALT word at 14
        tick();
        check("h_pc14",   32'(instr_pc), 14);
        check("h_data14", 32'(instr_data), 32'hF00E);
`ifdef IFETCH_HALT_DETECT_EN
        check("h_halted", 32'(halted), 1);
        check("h_state",  32'(dbg_state), 2);
        check("h_addr",   32'(imem_addr), 14);
        tick();
        check("h_drained", 32'(instr_valid), 0);
        check("h_hold",    32'(imem_addr), 14);
        check("h_still",   32'(halted), 1);
`else
        check("h_halted", 32'(halted), 0);
        check("h_addr",   32'(imem_addr), 15);
        tick();
        check("h_pc15",  32'(instr_pc), 15);
        check("h_addr16", 32'(imem_addr), 16);
        check("h_still", 32'(halted), 0);
`endif
        redirect_valid = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect_valid = 1'b0;
        check("hr_halted", 32'(halted), 0);
        check("hr_state",  32'(dbg_state), 1);
        check("hr_addr",   32'(imem_addr), 0);
        check("hr_valid",  32'(instr_valid), 0);
        tick();
        check("hr_pc0", 32'(instr_pc), 0);

        // Stall with head 0, then drain in order
        instr_ready = 1'b0;
        tick(); tick(); tick();
        check("st_count", 32'(q_count), 2);
        check("st_addr",  32'(imem_addr), 2);
        check("st_head",  32'(instr_pc), 0);
        instr_ready = 1'b1;
        tick(); check("dr_pc1", 32'(instr_pc), 1);
        tick(); check("dr_pc2", 32'(instr_pc), 2);
        tick(); check("dr_pc3", 32'(instr_pc), 3);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        tick(); check("w_fe", 32'(instr_pc), 32'hFE);
        check("w_data_fe", 32'(instr_data), 32'h10FE);
        tick(); check("w_ff", 32'(instr_pc), 32'hFF);
        tick(); check("w_00", 32'(instr_pc), 32'h00);
        tick(); check("w_01", 32'(instr_pc), 32'h01);

        // Enable removal: last enqueue on the leaving edge, queue retained and drains
        enable = 1'b0; instr_ready = 1'b0;
        tick();
        check("id_state", 32'(dbg_state), 0);
        check("id_count", 32'(q_count), 2);
        check("id_addr",  32'(imem_addr), 3);
        tick();
        check("id_hold_addr", 32'(imem_addr), 3);
        instr_ready = 1'b1;
        tick(); check("id_pc2", 32'(instr_pc), 2);
        check("id_count1", 32'(q_count), 1);
        tick(); check("id_empty", 32'(instr_valid), 0);

        // Redirect in IDLE loads pc, stays IDLE
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect_valid = 1'b0;
        check("ir_addr",  32'(imem_addr), 32'h40);
        check("ir_state", 32'(dbg_state), 0);

        // Asynchronous reset mid-fetch with full queue
        enable = 1'b1; instr_ready = 1'b0;
        tick(); tick(); tick();
        check("ar_count_pre", 32'(q_count), 2);
        check("ar_addr_pre",  32'(imem_addr), 32'h42);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(instr_valid), 0);
        check("ar_addr",  32'(imem_addr), 0);
        check("ar_count", 32'(q_count), 0);
        check("ar_state", 32'(dbg_state), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("ar_fetch", 32'(dbg_state), 1);
        tick();
        check("ar_pc0",   32'(instr_pc), 0);
        check("ar_valid1", 32'(instr_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
